sram_march_bist: RTL and testbench

Built-in self-test controller that sits directly upstream of `single_port_ram` and owns its write/read port during test. On `start` it runs a four-element March sequence over every address, compares each read against the expected pattern one cycle after the address is presented, and reports pass/fail, an error count, and the first failing location. In normal operation a mux outside this block hands the RAM port back to the functional master whenever `busy` is low.

---
 rtl/sram_march_bist.sv | 178 +++++++++++++++++
 tb/tb_sram_march_bist.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March BIST controller driving a single-port RAM: W0(P), R0W1 up, R1W0 down, R0 up.
// Reads are compared one cycle after their address is presented; first failure is captured.
module sram_march_bist #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN = 8'h55
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] ram_data_in_o,
    output logic [ADDR_WIDTH-1:0] ram_address_o,
    output logic                  ram_write_enable_o,
    input  logic [DATA_WIDTH-1:0] ram_data_out_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [7:0]            error_count_o,
    output logic [ADDR_WIDTH-1:0] fail_address_o,
    output logic [DATA_WIDTH-1:0] fail_expected_o,
    output logic [DATA_WIDTH-1:0] fail_actual_o
);

    typedef enum logic [3:0] {
        IDLE, W0, R0W1_RD, R0W1_WR, R1W0_RD, R1W0_WR, R0_RD, R0_DRAIN, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] PAT_INV  = ~PATTERN;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            errorCount_q, errorCount_d;
    logic [ADDR_WIDTH-1:0] failAddr_q, failAddr_d;
    logic [DATA_WIDTH-1:0] failExp_q, failExp_d;
    logic [DATA_WIDTH-1:0] failAct_q, failAct_d;
    logic                  pass_q, pass_d;
    logic                  cmpValid;
    logic [ADDR_WIDTH-1:0] cmpAddr;
    logic [DATA_WIDTH-1:0] cmpExp;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        errorCount_d = errorCount_q;
        failAddr_d   = failAddr_q;
        failExp_d    = failExp_q;
        failAct_d    = failAct_q;
        pass_d       = pass_q;
        cmpValid     = 1'b0;
        cmpAddr      = addr_q;
        cmpExp       = PATTERN;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = W0;
                    addr_d       = '0;
                    errorCount_d = '0;
                    failAddr_d   = '0;
                    failExp_d    = '0;
                    failAct_d    = '0;
                    pass_d       = 1'b0;
                end
            end
            W0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = R0W1_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            R0W1_RD: state_d = R0W1_WR;
            R0W1_WR: begin
                cmpValid = 1'b1;
                cmpExp   = PATTERN;
                if (addr_q == ADDR_MAX) begin
                    state_d = R1W0_RD;
                end else begin
                    state_d = R0W1_RD;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            R1W0_RD: state_d = R1W0_WR;
            R1W0_WR: begin
                cmpValid = 1'b1;
                cmpExp   = PAT_INV;
                if (addr_q == '0) begin
                    state_d = R0_RD;
                end else begin
                    state_d = R1W0_RD;
                    addr_d  = addr_q - ADDR_ONE;
                end
            end
            R0_RD: begin
                // Each cycle checks the read issued one cycle earlier.
                cmpValid = (addr_q != '0);
                cmpAddr  = addr_q - ADDR_ONE;
                if (addr_q == ADDR_MAX) begin
                    state_d = R0_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            R0_DRAIN: begin
                cmpValid = 1'b1;
                state_d  = DONE;
                addr_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        if (cmpValid && (ram_data_out_i != cmpExp)) begin
            if (errorCount_q != 8'hFF) errorCount_d = errorCount_q + 8'd1;
            if (errorCount_q == 8'd0) begin
                failAddr_d = cmpAddr;
                failExp_d  = cmpExp;
                failAct_d  = ram_data_out_i;
            end
        end
        if (state_q == R0_DRAIN) pass_d = (errorCount_d == 8'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            errorCount_q <= '0;
            failAddr_q   <= '0;
            failExp_q    <= '0;
            failAct_q    <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            errorCount_q <= errorCount_d;
            failAddr_q   <= failAddr_d;
            failExp_q    <= failExp_d;
            failAct_q    <= failAct_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        ram_write_enable_o = 1'b0;
        ram_address_o      = '0;
        ram_data_in_o      = '0;
        case (state_q)
            W0: begin
                ram_write_enable_o = 1'b1;
                ram_address_o      = addr_q;
                ram_data_in_o      = PATTERN;
            end
            R0W1_WR: begin
                ram_write_enable_o = 1'b1;
                ram_address_o      = addr_q;
                ram_data_in_o      = PAT_INV;
            end
            R1W0_WR: begin
                ram_write_enable_o = 1'b1;
                ram_address_o      = addr_q;
                ram_data_in_o      = PATTERN;
            end
            R0W1_RD, R1W0_RD, R0_RD, R0_DRAIN: ram_address_o = addr_q;
            default: ram_address_o = '0;
        endcase
    end

    assign busy_o          = (state_q != IDLE) && (state_q != DONE);
    assign done_o          = (state_q == DONE);
    assign pass_o          = pass_q;
    assign error_count_o   = errorCount_q;
    assign fail_address_o  = failAddr_q;
    assign fail_expected_o = failExp_q;
    assign fail_actual_o   = failAct_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural RAM with injectable faults plus an
// element-by-element March reference model computing the expected results.
module tb_sram_march_bist;

    localparam int D = 64;
    localparam logic [7:0] P = 8'h55;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ramDataIn;
    logic [5:0] ramAddress;
    logic       ramWe;
    logic [7:0] ramDataOut;
    logic       busy, done, pass;
    logic [7:0] errorCount;
    logic [5:0] failAddress;
    logic [7:0] failExpected, failActual;

    int compared = 0;
    int mismatched = 0;

    // Fault environment: 0 none, 1 stuck bits at one address, 2 writes dropped and reads return 0.
    int         faultMode = 0;
    logic [5:0] faultAddr = '0;
    logic [7:0] faultOr = '0;
    logic [7:0] faultAnd = 8'hFF;

    logic [7:0] mem [D];
    logic [7:0] modelMem [D];
    int         mCount;
    logic [5:0] mFirstAddr;
    logic [7:0] mFirstExp, mFirstAct;

    sram_march_bist dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .ram_data_in_o      (ramDataIn),
        .ram_address_o      (ramAddress),
        .ram_write_enable_o (ramWe),
        .ram_data_out_i     (ramDataOut),
        .busy_o             (busy),
        .done_o             (done),
        .pass_o             (pass),
        .error_count_o      (errorCount),
        .fail_address_o     (failAddress),
        .fail_expected_o    (failExpected),
        .fail_actual_o      (failActual)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] faultRead(input logic [5:0] a, input logic [7:0] v);
        if (faultMode == 2) return 8'h00;
        if (faultMode == 1 && a == faultAddr) return (v | faultOr) & faultAnd;
        return v;
    endfunction

    always @(posedge clk) begin
        if (ramWe && faultMode != 2) mem[ramAddress] <= ramDataIn;
        ramDataOut <= faultRead(ramAddress, mem[ramAddress]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelCompare(input int a, input logic [7:0] exp);
        logic [7:0] act;
        act = faultRead(6'(a), modelMem[a]);
        if (act != exp) begin
            if (mCount == 0) begin
                mFirstAddr = 6'(a);
                mFirstExp  = exp;
                mFirstAct  = act;
            end
            mCount++;
        end
    endtask

    task automatic modelWrite(input int a, input logic [7:0] v);
        if (faultMode != 2) modelMem[a] = v;
    endtask

    // March elements as plain loops over the model array.
    task automatic modelRun();
        mCount = 0; mFirstAddr = '0; mFirstExp = '0; mFirstAct = '0;
        for (int a = 0; a < D; a++) modelWrite(a, P);
        for (int a = 0; a < D; a++) begin modelCompare(a, P); modelWrite(a, ~P); end
        for (int a = D - 1; a >= 0; a--) begin modelCompare(a, ~P); modelWrite(a, P); end
        for (int a = 0; a < D; a++) modelCompare(a, P);
    endtask

    task automatic applyStimulus(input string tag, input int rstCycle, input bit extraStarts,
                                 input bit monitor);
        int cyc;
        int donePulses;
        int doneCycle;
        bit aborted;
        logic [7:0] expCount;
        modelRun();
        expCount = (mCount > 255) ? 8'hFF : 8'(mCount);
        donePulses = 0; doneCycle = -1; aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == 1) checkOutput({tag, " busyStart"}, busy, 1);
            if (cyc == 6 * D + 1) checkOutput({tag, " busyEnd"}, busy, 1);
            if (monitor && cyc == 65) begin
                checkOutput({tag, " mon65 addr"}, ramAddress, 0);
                checkOutput({tag, " mon65 we"}, ramWe, 0);
            end
            if (monitor && cyc == 66) begin
                checkOutput({tag, " mon66 addr"}, ramAddress, 0);
                checkOutput({tag, " mon66 we"}, ramWe, 1);
                checkOutput({tag, " mon66 data"}, ramDataIn, 8'hAA);
            end
            if (monitor && cyc == 193) begin
                checkOutput({tag, " mon193 addr"}, ramAddress, 63);
                checkOutput({tag, " mon193 we"}, ramWe, 0);
            end
            if (done) begin
                donePulses++;
                if (doneCycle < 0) begin
                    doneCycle = cyc;
                    checkOutput({tag, " passAtDone"}, pass, (mCount == 0));
                end
            end
            start = extraStarts && (cyc == 50 || cyc == 200);
            rst = (rstCycle != 0) && (cyc == rstCycle);
            @(posedge clk); #1;
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                checkOutput({tag, " rst busy"}, busy, 0);
                checkOutput({tag, " rst done"}, done, 0);
                checkOutput({tag, " rst we"}, ramWe, 0);
                checkOutput({tag, " rst errCount"}, errorCount, 0);
                checkOutput({tag, " rst failAddr"}, failAddress, 0);
                checkOutput({tag, " rst pass"}, pass, 0);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            checkOutput({tag, " doneCycle"}, doneCycle, 6 * D + 2);
            checkOutput({tag, " donePulses"}, donePulses, 1);
            checkOutput({tag, " pass"}, pass, (mCount == 0));
            checkOutput({tag, " errCount"}, errorCount, expCount);
            checkOutput({tag, " failAddr"}, failAddress, mFirstAddr);
            checkOutput({tag, " failExp"}, failExpected, mFirstExp);
            checkOutput({tag, " failAct"}, failActual, mFirstAct);
        end
    endtask

    initial begin
        int bad;
        int b;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset pass", pass, 0);
        checkOutput("reset errCount", errorCount, 0);
        checkOutput("reset ramAddr", ramAddress, 0);

        faultMode = 0;
        applyStimulus("clean", 0, 1'b0, 1'b1);
        bad = 0;
        for (int a = 0; a < D; a++) if (mem[a] != P) bad++;
        checkOutput("clean finalMem", bad, 0);

        faultMode = 1; faultAddr = 6'd5; faultOr = 8'h08; faultAnd = 8'hFF;
        applyStimulus("stuck5b3", 0, 1'b0, 1'b0);

        faultMode = 2;
        applyStimulus("allZero", 0, 1'b0, 1'b0);

        faultMode = 1; faultAddr = 6'd5; faultOr = 8'h08; faultAnd = 8'hFF;
        applyStimulus("rstMid", 100, 1'b0, 1'b0);
        faultMode = 0;
        applyStimulus("afterRst", 0, 1'b0, 1'b0);

        applyStimulus("extraStart", 0, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            faultMode = int'($urandom_range(0, 1));
            faultAddr = 6'($urandom_range(0, D - 1));
            b = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                faultOr = 8'h01 << b; faultAnd = 8'hFF;
            end else begin
                faultOr = 8'h00; faultAnd = ~(8'h01 << b);
            end
            applyStimulus($sformatf("rand%0d", r), 0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
